mem_port_scheduler: RTL and testbench
=====================================

# mem_port_scheduler

Shares the single accelerator memory port among the three memory clients: decompressor reads (ifmap), weight-buffer reads and compressor writes. It sits between the layer controller/clients and the testbench memory model. Each cycle it grants at most one client round-robin, drives the address from that client's auto-incrementing pointer, and tags each read in an in-order tag FIFO. Returned read data is steered back to the client that issued the read.

## Interface
Parameters:
- ADDR_W, `MEM_ADDR_SIZE: memory address width
- DATA_W, `MEM_BANDWIDTH*8: memory data width
- TAG_DEPTH, 16: maximum outstanding reads (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  layer start pulse: loads base addresses, flushes state
- ifmap_base_addr / weight_base_addr / compressor_base_addr  in  ADDR_W each  pointer bases, sampled on start
- decompressor_mem_req / weight_buffer_mem_req / compressor_mem_req  in  1 each  request, level
- decompressor_mem_ack / weight_buffer_mem_ack / compressor_mem_ack  out  1 each  grant this cycle
- compressed_data  in  DATA_W  write data from compressor
- mem_ready  in  1  memory accepts a command this cycle
- mem_addr  out  ADDR_W  command address
- mem_read_valid  out  1  read command issued
- mem_write_valid  out  1  write command issued
- mem_write_data  out  DATA_W  equals compressed_data
- mem_data  in  DATA_W  read return data
- mem_valid  in  1  read return valid
- decompressor_mem_data / weight_buffer_mem_data  out  DATA_W  equal mem_data
- decompressor_mem_data_valid / weight_buffer_mem_data_valid  out  1  routed return valid
- outstanding  out  $clog2(TAG_DEPTH)+1  reads in flight
- orphan_rsp  out  1  sticky: mem_valid seen with no outstanding read

## Operation
- Client index: 0 = decompressor, 1 = weight buffer, 2 = compressor.
- Eligible: req[i] & mem_ready. For i in {0,1}, also requires tag FIFO not full, evaluated before this cycle's pop. Compressor writes are never blocked by the FIFO.
- Round-robin: priority pointer rr_ptr, range 0..2. Search starts at rr_ptr. On a grant to i, rr_ptr <= (i+1) mod 3. No grant leaves rr_ptr unchanged.
- Grant i, combinational in the same cycle:
  - ack[i]=1
  - mem_addr = ptr[i]
  - mem_read_valid = (i<2), mem_write_valid = (i==2)
  - ptr[i] <= ptr[i]+1 at the edge, wrapping modulo 2^ADDR_W
- With no grant: mem_addr=0 and all acks and valids are 0. Grants are strictly one-hot or zero.
- Tag FIFO: push the client index on a read grant. On mem_valid with FIFO non-empty, pop and assert the valid output for the head client. Push and pop in the same cycle are both performed, and outstanding is unchanged.
- mem_valid with FIFO empty: response discarded, orphan_rsp <= 1.
- start, equal priority to rst except for bases:
  - ptr[i] <= base[i], rr_ptr <= 0
  - FIFO flushed, orphan_rsp <= 0
  - No grants in the start cycle.
  - Responses to reads issued before start are therefore orphans, and clients must drain before start.
- Reset values: ptrs 0, rr_ptr 0, FIFO empty, outstanding 0, orphan_rsp 0. All outputs 0 except the data passthroughs.

## Timing
- Request to ack/command: 0 cycles, combinational; the client holds req until it sees ack.
- Pointer update, rr_ptr update and FIFO push are visible the cycle after the grant.
- Return routing: data valid outputs are combinational from mem_valid and the FIFO head, 0 cycles.
- The full→not-full transition caused by a pop unblocks reads from the next cycle.
- Throughput: one command per cycle while mem_ready=1.

## Structure
- Shared package: MEMORY_SOURCE enum {IFMAP_BUFFER, WEIGHT_BUFFER, COMPRESSOR, NONE} and the per-client index constants. Reuse `MEM_ADDR_SIZE/`MEM_BANDWIDTH.
- One sub-module, mem_tag_fifo: synchronous FIFO, depth TAG_DEPTH, 2-bit entries, with full, empty and count outputs. The arbiter and pointers stay inline.

## Test plan
- Bases 0x100/0x200/0x300 via start; all three req held for 6 cycles, mem_ready=1 → acks 0,1,2,0,1,2; addresses 0x100,0x200,0x300,0x101,0x201,0x301.
- Only weight req is asserted, memory never returns → 16 grants, then weight ack stays 0 with outstanding=16. Compressor req is still granted every cycle.
- Interleaved decompressor/weight reads, returns delayed 5 cycles in order → each return asserts the matching *_mem_data_valid and never the other; outstanding returns to 0.
- FIFO full, same cycle mem_valid and decompressor req → no grant that cycle, grant the next; outstanding 16→15→16.
- mem_valid with nothing outstanding → no data valid output, orphan_rsp=1 until the next start.
- mem_ready=0 for 3 cycles with all req → no acks, rr_ptr and pointers frozen. Mid-stream start, or rst=1 → next-cycle pointers = bases (or 0), outstanding=0.

Source files
------------

// File: rtl/mem_port_scheduler_pkg.sv
// Shared types and constants for the accelerator memory port scheduler.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif

package mem_port_scheduler_pkg;

    localparam int unsigned MEM_ADDR_W  = `MEM_ADDR_SIZE;
    localparam int unsigned MEM_DATA_W  = `MEM_BANDWIDTH * 8;
    localparam int unsigned NUM_CLIENTS = 3;
    localparam int unsigned SRC_W       = 2;

    typedef enum logic [SRC_W-1:0] {
        IFMAP_BUFFER  = 2'd0,
        WEIGHT_BUFFER = 2'd1,
        COMPRESSOR    = 2'd2,
        NONE          = 2'd3
    } memory_source_e;

    localparam logic [SRC_W-1:0] CLIENT_DECOMP = 2'd0;
    localparam logic [SRC_W-1:0] CLIENT_WEIGHT = 2'd1;
    localparam logic [SRC_W-1:0] CLIENT_COMP   = 2'd2;

    // Next round-robin start point after a grant to idx (mod 3).
    function automatic logic [SRC_W-1:0] rr_advance(input logic [SRC_W-1:0] idx);
        return (idx == CLIENT_COMP) ? CLIENT_DECOMP : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mem_port_scheduler_if.sv
// Command/response bus between the scheduler and the memory model.
interface mem_port_scheduler_if
    import mem_port_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_valid;
    logic              mem_write_valid;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;

    modport master (
        input  mem_ready, mem_data, mem_valid,
        output mem_addr, mem_read_valid, mem_write_valid, mem_write_data
    );

    modport slave (
        output mem_ready, mem_data, mem_valid,
        input  mem_addr, mem_read_valid, mem_write_valid, mem_write_data
    );
endinterface

// File: rtl/mem_port_scheduler_tag_fifo.sv
// In-order tag FIFO recording which client issued each outstanding read.
module mem_tag_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Pointer/count/storage next state; flush discards all entries.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_port_scheduler.sv
// Round-robin sharing of the single memory port between decompressor reads,
// weight-buffer reads and compressor writes, with in-order read return routing.
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          ifmap_base_addr,
    input  logic [ADDR_W-1:0]          weight_base_addr,
    input  logic [ADDR_W-1:0]          compressor_base_addr,
    input  logic                       decompressor_mem_req,
    input  logic                       weight_buffer_mem_req,
    input  logic                       compressor_mem_req,
    output logic                       decompressor_mem_ack,
    output logic                       weight_buffer_mem_ack,
    output logic                       compressor_mem_ack,
    input  logic [DATA_W-1:0]          compressed_data,
    mem_port_scheduler_if.master       mem,
    output logic [DATA_W-1:0]          decompressor_mem_data,
    output logic [DATA_W-1:0]          weight_buffer_mem_data,
    output logic                       decompressor_mem_data_valid,
    output logic                       weight_buffer_mem_data_valid,
    output logic [$clog2(TAG_DEPTH):0] outstanding,
    output logic                       orphan_rsp
);
    logic [ADDR_W-1:0]      ptr_q [NUM_CLIENTS];
    logic [ADDR_W-1:0]      ptr_d [NUM_CLIENTS];
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   orphan_q, orphan_d;
    logic [NUM_CLIENTS-1:0] elig;
    logic [NUM_CLIENTS-1:0] grant;
    memory_source_e         grant_src;
    logic                   block;
    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [SRC_W-1:0]       fifo_head;

    assign block   = rst | start;
    assign elig[0] = decompressor_mem_req  & mem.mem_ready & ~fifo_full & ~block;
    assign elig[1] = weight_buffer_mem_req & mem.mem_ready & ~fifo_full & ~block;
    assign elig[2] = compressor_mem_req    & mem.mem_ready & ~block;

    // Round-robin search starting at rr_ptr; first eligible client wins.
    always_comb begin
        grant_src = NONE;
        for (int k = 0; k < int'(NUM_CLIENTS); k++) begin
            automatic logic [2:0]       sum  = {1'b0, rr_ptr_q} + 3'(k);
            automatic logic [SRC_W-1:0] cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (grant_src == NONE && elig[cand]) grant_src = memory_source_e'(cand);
        end
    end

    assign grant[0] = (grant_src == IFMAP_BUFFER);
    assign grant[1] = (grant_src == WEIGHT_BUFFER);
    assign grant[2] = (grant_src == COMPRESSOR);

    assign decompressor_mem_ack  = grant[0];
    assign weight_buffer_mem_ack = grant[1];
    assign compressor_mem_ack    = grant[2];

    // Command address comes from the granted client's pointer.
    always_comb begin
        mem.mem_addr = '0;
        case (grant_src)
            IFMAP_BUFFER:  mem.mem_addr = ptr_q[CLIENT_DECOMP];
            WEIGHT_BUFFER: mem.mem_addr = ptr_q[CLIENT_WEIGHT];
            COMPRESSOR:    mem.mem_addr = ptr_q[CLIENT_COMP];
            default:       mem.mem_addr = '0;
        endcase
    end

    assign mem.mem_read_valid  = grant[0] | grant[1];
    assign mem.mem_write_valid = grant[2];
    assign mem.mem_write_data  = compressed_data;

    assign fifo_pop = mem.mem_valid & ~fifo_empty & ~block;

    mem_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (SRC_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start),
        .push      (mem.mem_read_valid),
        .push_data (2'(grant_src)),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    assign decompressor_mem_data        = mem.mem_data;
    assign weight_buffer_mem_data       = mem.mem_data;
    assign decompressor_mem_data_valid  = fifo_pop & (fifo_head == CLIENT_DECOMP);
    assign weight_buffer_mem_data_valid = fifo_pop & (fifo_head == CLIENT_WEIGHT);
    assign orphan_rsp                   = orphan_q;

    // Pointer, priority and orphan-flag next state.
    always_comb begin
        ptr_d    = ptr_q;
        rr_ptr_d = rr_ptr_q;
        orphan_d = orphan_q;
        if (start) begin
            ptr_d[CLIENT_DECOMP] = ifmap_base_addr;
            ptr_d[CLIENT_WEIGHT] = weight_base_addr;
            ptr_d[CLIENT_COMP]   = compressor_base_addr;
            rr_ptr_d             = '0;
            orphan_d             = 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
                if (grant[i]) ptr_d[i] = ptr_q[i] + ADDR_W'(1);
            end
            if (grant_src != NONE) rr_ptr_d = rr_advance(2'(grant_src));
            if (mem.mem_valid && fifo_empty) orphan_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CLIENTS); i++) ptr_q[i] <= '0;
            rr_ptr_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            rr_ptr_q <= rr_ptr_d;
            orphan_q <= orphan_d;
        end
    end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed self-checking bench for mem_port_scheduler.
module tb_mem_port_scheduler;
    import mem_port_scheduler_pkg::*;

    localparam int unsigned AW = MEM_ADDR_W;
    localparam int unsigned DW = MEM_DATA_W;
    localparam int unsigned TD = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] ifmap_base_addr, weight_base_addr, compressor_base_addr;
    logic          dec_req, wt_req, comp_req;
    logic          dec_ack, wt_ack, comp_ack;
    logic [DW-1:0] compressed_data;
    logic [DW-1:0] dec_data, wt_data;
    logic          dec_valid, wt_valid;
    logic [$clog2(TD):0] outstanding;
    logic          orphan_rsp;

    int n_checks;
    int n_errors;

    mem_port_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    mem_port_scheduler #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .start                        (start),
        .ifmap_base_addr              (ifmap_base_addr),
        .weight_base_addr             (weight_base_addr),
        .compressor_base_addr         (compressor_base_addr),
        .decompressor_mem_req         (dec_req),
        .weight_buffer_mem_req        (wt_req),
        .compressor_mem_req           (comp_req),
        .decompressor_mem_ack         (dec_ack),
        .weight_buffer_mem_ack        (wt_ack),
        .compressor_mem_ack           (comp_ack),
        .compressed_data              (compressed_data),
        .mem                          (mem_bus),
        .decompressor_mem_data        (dec_data),
        .weight_buffer_mem_data       (wt_data),
        .decompressor_mem_data_valid  (dec_valid),
        .weight_buffer_mem_data_valid (wt_valid),
        .outstanding                  (outstanding),
        .orphan_rsp                   (orphan_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ack_vec();
        return 32'({comp_ack, wt_ack, dec_ack});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] r);
        {comp_req, wt_req, dec_req} = r;
    endtask

    logic [31:0] exp_ack  [6];
    logic [31:0] exp_addr [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        start = 1'b0;
        ifmap_base_addr = '0;
        weight_base_addr = '0;
        compressor_base_addr = '0;
        set_req(3'b000);
        compressed_data = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_data  = '0;
        mem_bus.mem_valid = 1'b0;
        exp_ack  = '{32'h1, 32'h2, 32'h4, 32'h1, 32'h2, 32'h4};
        exp_addr = '{32'h100, 32'h200, 32'h300, 32'h101, 32'h201, 32'h301};

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_orphan", 32'(orphan_rsp), 32'd0);
        chk("rst_acks", ack_vec(), 32'd0);
        chk("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        chk("rst_rvalid", 32'(mem_bus.mem_read_valid), 32'd0);
        chk("rst_wvalid", 32'(mem_bus.mem_write_valid), 32'd0);

        // Round robin across all three clients after loading bases.
        ifmap_base_addr      = AW'(16'h100);
        weight_base_addr     = AW'(16'h200);
        compressor_base_addr = AW'(16'h300);
        mem_bus.mem_ready = 1'b1;
        set_req(3'b111);
        start = 1'b1;
        #1;
        chk("start_no_grant", ack_vec(), 32'd0);
        tick();
        start = 1'b0;
        compressed_data = DW'(32'hC0FFEE01);
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_ack", ack_vec(), exp_ack[i]);
            chk("rr_addr", 32'(mem_bus.mem_addr), exp_addr[i]);
            chk("rr_rvalid", 32'(mem_bus.mem_read_valid), (i % 3 == 2) ? 32'd0 : 32'd1);
            chk("rr_wvalid", 32'(mem_bus.mem_write_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
            tick();
        end
        chk("wdata_pass", 32'(mem_bus.mem_write_data), 32'hC0FFEE01);
        set_req(3'b000);
        chk("rr_outstanding", 32'(outstanding), 32'd4);

        // Drain the four reads in issue order: dec, wt, dec, wt.
        for (int i = 0; i < 4; i++) begin
            mem_bus.mem_valid = 1'b1;
            mem_bus.mem_data  = DW'(32'hA0 + 32'(i));
            #1;
            chk("drain_dec_valid", 32'(dec_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("drain_wt_valid", 32'(wt_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        mem_bus.mem_valid = 1'b0;
        #1;
        chk("drain_outstanding", 32'(outstanding), 32'd0);

        // Alternating dec/wt reads with returns delayed five cycles.
        for (int c = 0; c < 11; c++) begin
            dec_req = (c < 6) && (c % 2 == 0);
            wt_req  = (c < 6) && (c % 2 == 1);
            mem_bus.mem_valid = (c >= 5);
            mem_bus.mem_data  = DW'(32'h5000 + 32'(c));
            #1;
            if (c < 6) begin
                chk("il_ack", ack_vec(), (c % 2 == 0) ? 32'h1 : 32'h2);
                chk("il_addr", 32'(mem_bus.mem_addr),
                    (c % 2 == 0) ? 32'h102 + 32'(c / 2) : 32'h202 + 32'(c / 2));
            end
            chk("il_dec_valid", 32'(dec_valid), (c >= 5 && (c - 5) % 2 == 0) ? 32'd1 : 32'd0);
            chk("il_wt_valid", 32'(wt_valid), (c >= 5 && (c - 5) % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        set_req(3'b000);
        mem_bus.mem_valid = 1'b0;
        #1;
        chk("il_outstanding", 32'(outstanding), 32'd0);

        // Weight reads fill the tag FIFO; memory never returns.
        set_req(3'b010);
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_ack", ack_vec(), 32'h2);
            chk("fill_addr", 32'(mem_bus.mem_addr), 32'h205 + 32'(i));
            tick();
        end
        chk("full_wt_blocked", ack_vec(), 32'd0);
        chk("full_outstanding", 32'(outstanding), 32'd16);
        set_req(3'b110);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("full_comp_ack", ack_vec(), 32'h4);
            chk("full_comp_addr", 32'(mem_bus.mem_addr), 32'h302 + 32'(i));
            chk("full_comp_wvalid", 32'(mem_bus.mem_write_valid), 32'd1);
            tick();
        end
        set_req(3'b000);

        // Full FIFO: return and dec request in the same cycle.
        set_req(3'b001);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = DW'(32'hDEADBEEF);
        #1;
        chk("pop_full_no_grant", ack_vec(), 32'd0);
        chk("pop_full_wt_valid", 32'(wt_valid), 32'd1);
        chk("pop_full_dec_valid", 32'(dec_valid), 32'd0);
        chk("pop_full_wt_data", 32'(wt_data), 32'hDEADBEEF);
        chk("pop_full_dec_data", 32'(dec_data), 32'hDEADBEEF);
        chk("pop_full_outstanding", 32'(outstanding), 32'd16);
        tick();
        mem_bus.mem_valid = 1'b0;
        #1;
        chk("unblock_outstanding", 32'(outstanding), 32'd15);
        chk("unblock_ack", ack_vec(), 32'h1);
        chk("unblock_addr", 32'(mem_bus.mem_addr), 32'h105);
        tick();
        set_req(3'b000);
        #1;
        chk("refull_outstanding", 32'(outstanding), 32'd16);

        // Memory stalls: nothing granted, state frozen.
        mem_bus.mem_ready = 1'b0;
        set_req(3'b111);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ack", ack_vec(), 32'd0);
            tick();
        end
        mem_bus.mem_ready = 1'b1;
        #1;
        chk("stall_resume_ack", ack_vec(), 32'h4);
        chk("stall_resume_addr", 32'(mem_bus.mem_addr), 32'h305);
        tick();

        // Mid-stream start flushes outstanding reads and reloads bases.
        ifmap_base_addr      = AW'(16'h400);
        weight_base_addr     = AW'(16'h500);
        compressor_base_addr = AW'(16'h600);
        start = 1'b1;
        #1;
        chk("restart_no_grant", ack_vec(), 32'd0);
        tick();
        start = 1'b0;
        set_req(3'b000);
        #1;
        chk("restart_outstanding", 32'(outstanding), 32'd0);
        chk("restart_orphan", 32'(orphan_rsp), 32'd0);
        mem_bus.mem_valid = 1'b1;
        #1;
        chk("orphan_dec_valid", 32'(dec_valid), 32'd0);
        chk("orphan_wt_valid", 32'(wt_valid), 32'd0);
        tick();
        mem_bus.mem_valid = 1'b0;
        #1;
        chk("orphan_set", 32'(orphan_rsp), 32'd1);
        tick();
        chk("orphan_sticky", 32'(orphan_rsp), 32'd1);
        set_req(3'b111);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("restart_rr_ack", ack_vec(), 32'(1 << i));
            chk("restart_rr_addr", 32'(mem_bus.mem_addr), 32'h400 + 32'(i) * 32'h100);
            tick();
        end
        set_req(3'b000);
        chk("orphan_held", 32'(orphan_rsp), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("orphan_cleared", 32'(orphan_rsp), 32'd0);
        chk("start2_outstanding", 32'(outstanding), 32'd0);

        // Reset mid-stream returns pointers to zero.
        set_req(3'b111);
        #1;
        chk("pre_rst_addr", 32'(mem_bus.mem_addr), 32'h400);
        tick();
        rst = 1'b1;
        #1;
        chk("in_rst_no_grant", ack_vec(), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_outstanding", 32'(outstanding), 32'd0);
        chk("post_rst_ack", ack_vec(), 32'h1);
        chk("post_rst_addr", 32'(mem_bus.mem_addr), 32'h0);
        tick();
        set_req(3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
